// File: rtl/synchronizer.sv
// synchronizer: input-conditioning front end of the traffic light controller.
// Brings the asynchronous external reset and the three asynchronous request
// inputs (sensor, walk_request, reprogram) into the clock domain through
// STAGES-deep flop chains. The reset is asserted asynchronously and released
// synchronously. The data chains are cleared directly by the raw reset, so
// their outputs drop immediately when reset is asserted.
//
// Optional feature macro: SYNCHRONIZER_FILTER_EN
//   When defined, each data chain gets one extra flop plus an agreement
//   register. An output follows the chain only while its last two stages
//   agree, and holds its previous value otherwise. This adds one cycle of
//   latency and removes single-cycle glitches. The reset chain is unaffected.
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor,
    input  logic walk_request,
    input  logic reprogram,
    output logic reset_sync_global,
    output logic sensor_sync,
    output logic wr_sync,
    output logic prog_sync
);

    // Catch an illegal chain depth at elaboration time.
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("synchronizer: STAGES must be in the range 2..4");
    end

`ifdef SYNCHRONIZER_FILTER_EN
    localparam int CHAIN_LEN = STAGES + 1;
`else
    localparam int CHAIN_LEN = STAGES;
`endif

    localparam int NUM_REQ = 3;

    // Reset chain: bit 0 is the first flop and bit STAGES-1 drives the output.
    logic [STAGES-1:0] r_rst_chain;

    // Raw request inputs, indexed by channel: 0 sensor, 1 walk, 2 reprogram.
    logic [NUM_REQ-1:0] w_raw;

    // Conditioned request outputs, indexed the same way as w_raw.
    logic [NUM_REQ-1:0] w_out;

    // Data chains: bit 0 holds the newest sample and bit j the sample taken
    // j edges earlier.
    logic [CHAIN_LEN-1:0] r_chain [NUM_REQ];

    assign w_raw = {reprogram, walk_request, sensor};

    // Reset sequencer: clear on raw reset, then shift in ones once released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_chain <= '0;
        end else begin
            r_rst_chain <= {r_rst_chain[STAGES-2:0], 1'b1};
        end
    end

    assign reset_sync_global = r_rst_chain[STAGES-1];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req

        // Sample the raw request on every edge; raw reset clears the chain.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_chain[g] <= '0;
            end else begin
                r_chain[g] <= {r_chain[g][CHAIN_LEN-2:0], w_raw[g]};
            end
        end

`ifdef SYNCHRONIZER_FILTER_EN
        // The last two stages must agree before the output may move.
        logic w_agree;
        logic r_hold;

        assign w_agree  = (r_chain[g][STAGES] == r_chain[g][STAGES-1]);
        assign w_out[g] = w_agree ? r_chain[g][STAGES] : r_hold;

        // Remember the last presented value so disagreement can hold it.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_hold <= 1'b0;
            end else begin
                r_hold <= w_out[g];
            end
        end
`else
        assign w_out[g] = r_chain[g][STAGES-1];
`endif
    end

    assign sensor_sync = w_out[0];
    assign wr_sync     = w_out[1];
    assign prog_sync   = w_out[2];

endmodule

// File: tb/tb_synchronizer.sv
// tb_synchronizer: randomized scoreboard bench for synchronizer.
// A reference model records the input samples taken at each rising edge since
// reset release and pushes the expected outputs for that cycle into a queue.
// A monitor on the falling edge pops each entry and compares it with the DUT.
module tb_synchronizer;

    localparam int STAGES = 2;

    bit   clock;
    logic reset;
    logic sensor;
    logic walk_request;
    logic reprogram;
    logic reset_sync_global;
    logic sensor_sync;
    logic wr_sync;
    logic prog_sync;

    typedef struct packed {
        logic       rsg;
        logic [2:0] req;   // {prog, wr, sensor}
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    synchronizer #(.STAGES(STAGES)) dut (
        .clock             (clock),
        .reset             (reset),
        .sensor            (sensor),
        .walk_request      (walk_request),
        .reprogram         (reprogram),
        .reset_sync_global (reset_sync_global),
        .sensor_sync       (sensor_sync),
        .wr_sync           (wr_sync),
        .prog_sync         (prog_sync)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: edges_high counts rising edges seen with reset high;
    // hist[j] is the sample {prog, wr, sensor} taken j edges ago.
    initial begin : model
        int         edges_high;
        logic [2:0] hist[$];
        logic [2:0] held;
        logic [2:0] a;
        logic [2:0] b;
        exp_t       e;
        edges_high = 0;
        held = '0;
        forever begin
            @(posedge clock);
            if (reset === 1'b1) begin
                edges_high++;
                hist.push_front({reprogram, walk_request, sensor});
                if (hist.size() > 8) void'(hist.pop_back());
            end
            #3;
            if (reset !== 1'b1) begin
                edges_high = 0;
                hist.delete();
                held = '0;
            end
            a = (STAGES - 1 < hist.size()) ? hist[STAGES-1] : 3'b000;
            e.rsg = (edges_high >= STAGES);
`ifdef SYNCHRONIZER_FILTER_EN
            b = (STAGES < hist.size()) ? hist[STAGES] : 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (a[i] == b[i]) held[i] = b[i];
            end
            e.req = held;
`else
            b = a;
            e.req = b;
`endif
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented cycle on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reset_sync_global", reset_sync_global, e.rsg);
                check("sensor_sync",       sensor_sync,       e.req[0]);
                check("wr_sync",           wr_sync,           e.req[1]);
                check("prog_sync",         prog_sync,         e.req[2]);
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic edge_plus(input int d);
        @(posedge clock);
        #d;
    endtask

    initial begin : stimulus
        int wait_cycles;
        reset        = 1'b0;
        sensor       = 1'b1;
        walk_request = 1'b1;
        reprogram    = 1'b1;

        // Reset hold with all requests high.
        repeat (3) @(posedge clock);
        edge_plus(2);
        sensor       = 1'b0;
        walk_request = 1'b0;
        reprogram    = 1'b0;

        // Reset release 2 ns after an edge.
        edge_plus(2);
        reset = 1'b1;
        repeat (3) @(posedge clock);

        // Sensor rises mid-cycle; other outputs stay low.
        edge_plus(4);
        sensor = 1'b1;
        repeat (4) @(posedge clock);
        edge_plus(2);
        sensor = 1'b0;
        repeat (4) @(posedge clock);

        // Staggered requests after a fresh reset release.
        edge_plus(2);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        edge_plus(2);
        reset = 1'b1;
        #5 sensor       = 1'b1;
        #9 walk_request = 1'b1;
        #6 reprogram    = 1'b1;
        repeat (6) @(posedge clock);

        // Mid-operation reset with all outputs high, then recovery.
        edge_plus(2);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        edge_plus(2);
        reset = 1'b1;
        repeat (6) @(posedge clock);

        // Glitch and multi-cycle pulses on walk_request.
        edge_plus(2);
        sensor = 1'b0; walk_request = 1'b0; reprogram = 1'b0;
        repeat (4) @(posedge clock);
        edge_plus(2);
        walk_request = 1'b1;
        edge_plus(2);
        walk_request = 1'b0;
        repeat (5) @(posedge clock);
        edge_plus(2);
        walk_request = 1'b1;
        repeat (2) @(posedge clock);
        edge_plus(2);
        walk_request = 1'b0;
        repeat (6) @(posedge clock);

        // Randomized traffic with occasional mid-operation resets.
        for (int c = 0; c < 600; c++) begin
            edge_plus(2);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                wait_cycles = $urandom_range(1, 3);
                repeat (wait_cycles) @(posedge clock);
                #2;
                reset = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) sensor       = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 2) == 0) walk_request = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 2) == 0) reprogram    = $urandom_range(0, 1) != 0;
        end

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clock);
        for (int t = 0; t < 20 && exp_q.size() > 1; t++) @(negedge clock);
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() <= 1) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d entries left, expected at most 1", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
